// File: rtl/mmu_pkg.sv
// Shared definitions for the mmu_array systolic matrix-multiply unit:
// FSM state encoding, default geometry and the saturating accumulate helper
// used by the PEs when MMU_SAT_EN is defined.
package mmu_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_K_MAX  = 256;

  // Width the saturating add works in; accumulators up to 63 bits fit exactly.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Adds two sign-extended w-bit values and clamps the sum to the w-bit
  // signed range; sat reports whether a clamp happened.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int w);
    logic signed [SAT_W-1:0] sum_v;
    logic signed [SAT_W-1:0] hi_v;
    logic signed [SAT_W-1:0] lo_v;
    sat_res_t                res_v;
    sum_v = a + b;
    hi_v  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_v  = -(64'sd1 <<< (w - 1));
    if (sum_v > hi_v) begin
      res_v.sat = 1'b1;
      res_v.val = hi_v;
    end else if (sum_v < lo_v) begin
      res_v.sat = 1'b1;
      res_v.val = lo_v;
    end else begin
      res_v.sat = 1'b0;
      res_v.val = sum_v;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/mmu_array_if.sv
// Job control, operand stream and result stream of mmu_array.
// master: the side that issues jobs/operands and consumes rows; slave: the array.
interface mmu_array_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int KW     = 9
);
  localparam int RW = $clog2(ROWS);

  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   a_col;
  logic [COLS*DATA_W-1:0]   b_row;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*ACC_W-1:0]    c_row;
  logic [RW-1:0]            c_row_idx;
  logic                     out_last;
  logic                     sat_flag;

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  busy, in_ready, out_valid, c_row, c_row_idx, out_last, sat_flag
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output busy, in_ready, out_valid, c_row, c_row_idx, out_last, sat_flag
  );
endinterface

// File: rtl/mmu_pe.sv
// One processing element of the output-stationary grid: forwards A right and
// B down through registers and accumulates the signed product every cycle.
// With MMU_SAT_EN defined the accumulator clamps and reports a sticky
// saturation bit; otherwise it wraps and the bit stays 0.
module mmu_pe
  import mmu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);
  localparam int PW = 2 * DATA_W;

  logic        [DATA_W-1:0] a_r;
  logic        [DATA_W-1:0] b_r;
  logic signed [PW-1:0]     a_x_s;
  logic signed [PW-1:0]     b_x_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_nxt_s;
  logic                     sat_r;
  logic                     sat_hit_s;

  // Full-precision signed product, then sign-extended to the accumulator.
  assign a_x_s      = PW'($signed(a_in));
  assign b_x_s      = PW'($signed(b_in));
  assign prod_s     = a_x_s * b_x_s;
  assign prod_ext_s = ACC_W'(prod_s);

`ifdef MMU_SAT_EN
  sat_res_t sum_s;
  assign sum_s     = sat_add(SAT_W'(acc_r), SAT_W'(prod_ext_s), ACC_W);
  assign acc_nxt_s = sum_s.val[ACC_W-1:0];
  assign sat_hit_s = sum_s.sat;
`else
  assign acc_nxt_s = acc_r + prod_ext_s;
  assign sat_hit_s = 1'b0;
`endif

  // Operand pass-through, accumulate, and clear at job start.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= {DATA_W{1'b0}};
      b_r   <= {DATA_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
      sat_r <= 1'b0;
    end else begin
      a_r <= a_in;
      b_r <= b_in;
      if (clear) begin
        acc_r <= {ACC_W{1'b0}};
        sat_r <= 1'b0;
      end else begin
        acc_r <= acc_nxt_s;
        sat_r <= sat_r | sat_hit_s;
      end
    end
  end

  assign a_out = a_r;
  assign b_out = b_r;
  assign acc   = acc_r;
  assign sat   = sat_r;
endmodule

// File: rtl/mmu_array.sv
// ROWS x COLS output-stationary systolic matrix multiplier, C = A * B.
// Operands enter through per-lane skew shift registers, the FSM walks
// IDLE -> LOAD -> DRAIN -> OUT, and results leave one registered row at a time.
// Optional feature macro: MMU_SAT_EN (saturating accumulators, sticky sat_flag).
module mmu_array
  import mmu_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_MAX  = DEF_K_MAX,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input logic        clk,
  input logic        reset,
  mmu_array_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(ROWS + COLS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  state_e                 state_r, state_nxt_s;
  logic [KW-1:0]          k_len_r, k_len_nxt_s;
  logic [KW-1:0]          beat_cnt_r, beat_cnt_nxt_s;
  logic [DW-1:0]          drain_cnt_r, drain_cnt_nxt_s;
  logic [RW-1:0]          idx_r, idx_nxt_s;
  logic [RW-1:0]          row_sel_s;
  logic                   clear_s, beat_s, load_row_s;
  logic                   out_valid_r, out_last_r, sat_flag_r;
  logic [COLS*ACC_W-1:0]  c_row_r, c_row_nxt_s;
  logic [ROWS*COLS-1:0]   pe_sat_s;

  logic [DATA_W-1:0] a_bus_s [ROWS][COLS+1];
  logic [DATA_W-1:0] b_bus_s [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc_s   [ROWS][COLS];

  assign beat_s = (state_r == ST_LOAD) && bus.in_valid;

  // Row i of A: entry register plus i delay stages; zeros when no beat.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic [DATA_W-1:0] sk_r [i+1];
    // Shift the A lane one stage per cycle so bubbles keep alignment.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int n = 0; n <= i; n++) sk_r[n] <= {DATA_W{1'b0}};
      end else begin
        sk_r[0] <= beat_s ? bus.a_col[i*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        for (int n = 1; n <= i; n++) sk_r[n] <= sk_r[n-1];
      end
    end
    assign a_bus_s[i][0] = sk_r[i];
  end

  // Column j of B: entry register plus j delay stages; zeros when no beat.
  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic [DATA_W-1:0] sk_r [j+1];
    // Shift the B lane one stage per cycle so bubbles keep alignment.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int n = 0; n <= j; n++) sk_r[n] <= {DATA_W{1'b0}};
      end else begin
        sk_r[0] <= beat_s ? bus.b_row[j*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        for (int n = 1; n <= j; n++) sk_r[n] <= sk_r[n-1];
      end
    end
    assign b_bus_s[0][j] = sk_r[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .a_in  (a_bus_s[i][j]),
        .b_in  (b_bus_s[i][j]),
        .a_out (a_bus_s[i][j+1]),
        .b_out (b_bus_s[i+1][j]),
        .acc   (acc_s[i][j]),
        .sat   (pe_sat_s[i*COLS+j])
      );
    end
  end

  // Next-state, counter updates and row-load strobes for the job FSM.
  always_comb begin
    state_nxt_s     = state_r;
    k_len_nxt_s     = k_len_r;
    beat_cnt_nxt_s  = beat_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    idx_nxt_s       = idx_r;
    clear_s         = 1'b0;
    load_row_s      = 1'b0;
    row_sel_s       = idx_r + RW'(1);
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          clear_s         = 1'b1;
          k_len_nxt_s     = bus.k_len;
          beat_cnt_nxt_s  = {KW{1'b0}};
          drain_cnt_nxt_s = {DW{1'b0}};
          idx_nxt_s       = {RW{1'b0}};
          state_nxt_s     = (bus.k_len == {KW{1'b0}}) ? ST_DRAIN : ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (beat_s && (beat_cnt_r == k_len_r - KW'(1))) begin
          state_nxt_s = ST_DRAIN;
        end else if (beat_s) begin
          beat_cnt_nxt_s = beat_cnt_r + KW'(1);
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_OUT;
          load_row_s  = 1'b1;
          row_sel_s   = {RW{1'b0}};
        end else begin
          drain_cnt_nxt_s = drain_cnt_r + DW'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready && (idx_r == ROW_LAST)) begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = {RW{1'b0}};
        end else if (bus.out_ready) begin
          idx_nxt_s  = idx_r + RW'(1);
          load_row_s = 1'b1;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Gather the selected accumulator row for the output register.
  always_comb begin
    c_row_nxt_s = {(COLS*ACC_W){1'b0}};
    for (int j = 0; j < COLS; j++) begin
      c_row_nxt_s[j*ACC_W +: ACC_W] = acc_s[row_sel_s][j];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Job counters, registered result outputs and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_len_r     <= {KW{1'b0}};
      beat_cnt_r  <= {KW{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
      idx_r       <= {RW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      c_row_r     <= {(COLS*ACC_W){1'b0}};
      sat_flag_r  <= 1'b0;
    end else begin
      k_len_r     <= k_len_nxt_s;
      beat_cnt_r  <= beat_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      out_valid_r <= (state_nxt_s == ST_OUT);
      out_last_r  <= (state_nxt_s == ST_OUT) && (idx_nxt_s == ROW_LAST);
      c_row_r     <= load_row_s ? c_row_nxt_s : c_row_r;
      sat_flag_r  <= clear_s ? 1'b0 : (sat_flag_r | (|pe_sat_s));
    end
  end

  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.in_ready  = (state_r == ST_LOAD);
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.c_row     = c_row_r;
  assign bus.c_row_idx = idx_r;
  assign bus.sat_flag  = sat_flag_r;
endmodule

// File: tb/tb_mmu_array.sv
// Scoreboard bench for mmu_array: each job pushes its expected rows, and a
// monitor per DUT pops and compares on every accepted output row. A second
// instance with 16-bit accumulators exercises overflow behaviour.
`timescale 1ns/1ps
module tb_mmu_array;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmu_array_if #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .KW(9)) ifm ();
  mmu_array_if #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(16), .KW(9)) if16 ();

  mmu_array #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .K_MAX(256)) dut (
    .clk(clk), .reset(reset), .bus(ifm));
  mmu_array #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(16), .K_MAX(256)) dut16 (
    .clk(clk), .reset(reset), .bus(if16));

  typedef struct {
    logic [127:0] row;
    logic [1:0]   idx;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp16_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int a_m [4][4];
  int b_m [4][4];
  int c_m [4][4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] row_of(input int i);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(c_m[i][j]);
    return r;
  endfunction

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (!reset && ifm.out_valid && ifm.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", {126'd0, ifm.c_row_idx}, 128'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("row_data", ifm.c_row, e.row);
        check("row_idx", {126'd0, ifm.c_row_idx}, {126'd0, e.idx});
        check("row_last", {127'd0, ifm.out_last}, {127'd0, e.last});
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (!reset && if16.out_valid && if16.out_ready) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_row16", {126'd0, if16.c_row_idx}, 128'hDEAD);
      end else begin
        exp_t e;
        e = exp16_q.pop_front();
        check("ovf_row", {64'd0, if16.c_row}, e.row);
        check("ovf_idx", {126'd0, if16.c_row_idx}, {126'd0, e.idx});
        check("ovf_last", {127'd0, if16.out_last}, {127'd0, e.last});
      end
    end
  end

  task automatic model_push(input int k);
    exp_t e;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        c_m[i][j] = 0;
        for (int kk = 0; kk < k; kk++) c_m[i][j] += a_m[i][kk] * b_m[kk][j];
      end
    for (int i = 0; i < 4; i++) begin
      e.row = row_of(i);
      e.idx = 2'(i);
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input int kk);
    ifm.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) ifm.a_col[i*8 +: 8] = 8'(a_m[i][kk]);
    for (int j = 0; j < 4; j++) ifm.b_row[j*8 +: 8] = 8'(b_m[kk][j]);
  endtask

  task automatic run_job(input int k, input int gap, input bit stall, input bit noise);
    int c0;
    int cnt;
    bit stalled;
    int exp_len;
    model_push(k);
    ifm.start = 1'b1;
    ifm.k_len = 9'(k);
    step();
    ifm.start = 1'b0;
    c0 = cyc;
    check("in_ready_after_start", {127'd0, ifm.in_ready}, {127'd0, (k > 0)});
    for (int kk = 0; kk < k; kk++) begin
      drive_beat(kk);
      step();
      if (kk < k - 1) begin
        for (int g = 0; g < gap; g++) begin
          ifm.in_valid = 1'b0;
          ifm.a_col = 32'h7F7F7F7F;
          ifm.b_row = 32'h81818181;
          step();
        end
      end
    end
    ifm.in_valid = noise;
    ifm.a_col = 32'h5A5A5A5A;
    ifm.b_row = 32'hA5A5A5A5;
    cnt = 0;
    stalled = 1'b0;
    while (ifm.busy && cnt < 100) begin
      if (stall && !stalled && ifm.out_valid && ifm.c_row_idx == 2'd2) begin
        ifm.out_ready = 1'b0;
        ifm.start = 1'b1;
        ifm.k_len = 9'd3;
        for (int s = 0; s < 5; s++) begin
          step();
          check("stall_idx", {126'd0, ifm.c_row_idx}, 128'd2);
          check("stall_row", ifm.c_row, row_of(2));
          check("stall_valid", {127'd0, ifm.out_valid}, 128'd1);
        end
        ifm.out_ready = 1'b1;
        ifm.start = 1'b0;
        stalled = 1'b1;
      end else begin
        step();
        cnt++;
      end
    end
    ifm.in_valid = 1'b0;
    exp_len = k + 11 + ((k > 0) ? gap * (k - 1) : 0) + (stall ? 5 : 0);
    check("job_done", {127'd0, ifm.busy}, 128'd0);
    check("job_len", 128'(cyc - c0), 128'(exp_len));
    check("rows_drained", 128'(exp_q.size()), 128'd0);
    check("sat_flag", {127'd0, ifm.sat_flag}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    exp_t e;
    int cnt;
    logic [15:0] ovf_v;
    reset = 1'b1;
    ifm.start = 1'b0; ifm.k_len = '0; ifm.in_valid = 1'b0;
    ifm.a_col = '0; ifm.b_row = '0; ifm.out_ready = 1'b1;
    if16.start = 1'b0; if16.k_len = '0; if16.in_valid = 1'b0;
    if16.a_col = '0; if16.b_row = '0; if16.out_ready = 1'b1;
    step();
    step();
    check("rst_busy", {127'd0, ifm.busy}, 128'd0);
    check("rst_in_ready", {127'd0, ifm.in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, ifm.out_valid}, 128'd0);
    check("rst_out_last", {127'd0, ifm.out_last}, 128'd0);
    check("rst_sat_flag", {127'd0, ifm.sat_flag}, 128'd0);
    check("rst_c_row", ifm.c_row, 128'd0);
    check("rst_c_row_idx", {126'd0, ifm.c_row_idx}, 128'd0);
    reset = 1'b0;
    step();

    // Identity A, B[k][j] = 4k + j: rows read back as B rows.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = 4 * i + j;
      end
    run_job(4, 0, 1'b0, 1'b0);
    // Same job with two bubble cycles between beats.
    run_job(4, 2, 1'b0, 1'b1);

    // Signed single beat: -128 * -128 everywhere.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = -128;
        b_m[i][j] = -128;
      end
    run_job(1, 0, 1'b0, 1'b0);

    // Empty inner dimension gives all-zero rows.
    run_job(0, 0, 1'b0, 1'b1);

    // Mixed-sign job with a 5-cycle stall at row 2 and a start pulse while busy.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = i + j + 1;
        b_m[i][j] = j - 2 * i;
      end
    run_job(3, 0, 1'b1, 1'b1);

    // Reset in the middle of LOAD, then a clean identity job.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = 4 * i + j;
      end
    ifm.start = 1'b1;
    ifm.k_len = 9'd4;
    step();
    ifm.start = 1'b0;
    drive_beat(0);
    step();
    drive_beat(1);
    step();
    reset = 1'b1;
    ifm.in_valid = 1'b0;
    step();
    reset = 1'b0;
    check("mid_rst_busy", {127'd0, ifm.busy}, 128'd0);
    check("mid_rst_in_ready", {127'd0, ifm.in_ready}, 128'd0);
    check("mid_rst_out_valid", {127'd0, ifm.out_valid}, 128'd0);
    for (int s = 0; s < 12; s++) step();
    check("mid_rst_quiet", {127'd0, ifm.busy}, 128'd0);
    run_job(4, 0, 1'b0, 1'b0);

    // Overflow on the 16-bit-accumulator instance: four beats of 127 * 127.
`ifdef MMU_SAT_EN
    ovf_v = 16'h7FFF;
`else
    ovf_v = 16'hFC04;
`endif
    for (int i = 0; i < 4; i++) begin
      e.row = {64'd0, {4{ovf_v}}};
      e.idx = 2'(i);
      e.last = (i == 3);
      exp16_q.push_back(e);
    end
    if16.start = 1'b1;
    if16.k_len = 9'd4;
    step();
    if16.start = 1'b0;
    for (int kk = 0; kk < 4; kk++) begin
      if16.in_valid = 1'b1;
      if16.a_col = {4{8'sd127}};
      if16.b_row = {4{8'sd127}};
      step();
    end
    if16.in_valid = 1'b0;
    cnt = 0;
    while (if16.busy && cnt < 100) begin
      step();
      cnt++;
    end
    check("ovf_done", {127'd0, if16.busy}, 128'd0);
    check("ovf_rows_drained", 128'(exp16_q.size()), 128'd0);
`ifdef MMU_SAT_EN
    check("ovf_sat_flag", {127'd0, if16.sat_flag}, 128'd1);
`else
    check("ovf_sat_flag", {127'd0, if16.sat_flag}, 128'd0);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
